// File: rtl/acia_pkg.sv
// acia_pkg: shared types, the baud rate table and the elaboration-time
// divisor arithmetic used by the 6551 ACIA baud generator.
package acia_pkg;

    typedef logic [3:0] sbr_t;

    localparam int NUM_RATES   = 16;
    localparam int SYNC_STAGES = 3;

    // Baud rate x100 per R_SBR index; index 0 is the bypass entry.
    localparam logic [NUM_RATES-1:0][31:0] BAUD_X100 = {
        32'd1920000, 32'd960000, 32'd720000, 32'd480000,
        32'd360000,  32'd240000, 32'd180000, 32'd120000,
        32'd60000,   32'd30000,  32'd15000,  32'd13458,
        32'd10992,   32'd7500,   32'd5000,   32'd0
    };

    // Full fixed-point divisor D, rounded half up.
    function automatic longint unsigned acia_frac_div(input longint unsigned xtli,
                                                      input int frac_w,
                                                      input sbr_t idx);
        longint unsigned den;
        longint unsigned num;
        if (idx == '0) begin
            return 64'd1 << frac_w;
        end
        den = 64'd16 * 64'(BAUD_X100[idx]);
        num = (xtli << frac_w) * 64'd100;
        return (num + (den >> 1)) / den;
    endfunction

    // Integer part of the fixed-point divisor.
    function automatic longint unsigned acia_int_part(input longint unsigned xtli,
                                                      input int frac_w,
                                                      input sbr_t idx);
        return acia_frac_div(xtli, frac_w, idx) >> frac_w;
    endfunction

    // Fractional part of the fixed-point divisor.
    function automatic longint unsigned acia_frac_part(input longint unsigned xtli,
                                                       input int frac_w,
                                                       input sbr_t idx);
        return acia_frac_div(xtli, frac_w, idx) & ((64'd1 << frac_w) - 64'd1);
    endfunction

    // Plain integer divisor, rounded half up, for builds without dithering.
    function automatic longint unsigned acia_int_div(input longint unsigned xtli,
                                                     input sbr_t idx);
        longint unsigned den;
        if (idx == '0) begin
            return 64'd1;
        end
        den = 64'd16 * 64'(BAUD_X100[idx]);
        return (xtli * 64'd100 + (den >> 1)) / den;
    endfunction

    // A divisor must be at least 1 and must fit the down-counter.
    function automatic bit acia_div_ok(input longint unsigned div, input int cnt_w);
        return (div >= 64'd1) && (div < (64'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/acia_tick_sync.sv
// acia_tick_sync: three-flop synchroniser for the external RxC clock plus a
// registered rising-edge detector producing a one-cycle sample tick.
module acia_tick_sync
    import acia_pkg::*;
(
    input  logic XTLI,
    input  logic RESET,
    input  logic RXC_IN,
    output logic rx_tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_tick_q;

    // Shift RXC_IN through the chain; edge detect on the last two stages only
    // so the first flop is free to resolve metastability.
    always_ff @(posedge XTLI or negedge RESET) begin
        if (!RESET) begin
            sync_q    <= '0;
            rx_tick_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], RXC_IN};
            rx_tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign rx_tick = rx_tick_q;

endmodule

// File: rtl/acia_baud_gen.sv
// acia_baud_gen: 16x baud tick generator for the 6551 ACIA, clocked from XTLI.
// Define ACIA_BRGEN_FRAC_EN to build in the fractional (dithered) divisor;
// without it every period is the rounded integer divisor.
module acia_baud_gen
    import acia_pkg::*;
#(
    parameter int XTLI_FREQ = 1_843_200,
    parameter int CNT_W     = 16,
    parameter int FRAC_W    = 8
) (
    input  logic       XTLI,
    input  logic       RESET,
    input  logic [3:0] R_SBR,
    input  logic       R_RCS,
    input  logic       RXC_IN,
    output logic       TX_TICK,
    output logic       RX_TICK,
    output logic       BCLK
);

    logic [NUM_RATES-1:0][CNT_W-1:0]  int_tbl;
`ifdef ACIA_BRGEN_FRAC_EN
    logic [NUM_RATES-1:0][FRAC_W-1:0] frac_tbl;
`endif

    // FRAC_W is kept in a usable range in every build so one parameter set
    // works with or without the fractional option.
    if (FRAC_W < 1 || FRAC_W > 32) begin : g_bad_frac_w
        $fatal(1, "acia_baud_gen: FRAC_W=%0d out of range", FRAC_W);
    end

    // Per-rate divisor constants, all resolved at elaboration.
    genvar gi;
    for (gi = 0; gi < NUM_RATES; gi++) begin : g_tbl
`ifdef ACIA_BRGEN_FRAC_EN
        localparam longint unsigned INT_V  = acia_int_part(64'(XTLI_FREQ), FRAC_W, sbr_t'(gi));
        localparam longint unsigned FRAC_V = acia_frac_part(64'(XTLI_FREQ), FRAC_W, sbr_t'(gi));
        assign frac_tbl[gi] = FRAC_W'(FRAC_V);
`else
        localparam longint unsigned INT_V  = acia_int_div(64'(XTLI_FREQ), sbr_t'(gi));
`endif
        assign int_tbl[gi] = CNT_W'(INT_V);
        if (!acia_div_ok(INT_V, CNT_W)) begin : g_bad_div
            $fatal(1, "acia_baud_gen: divisor for SBR %0d does not fit %0d bits", gi, CNT_W);
        end
    end

    sbr_t             sbr_q;
    logic [CNT_W-1:0] cnt;
    logic             tx_tick_q;
    logic             bclk_q;
    logic             rx_tick_ext;

    logic             rate_change;
    logic             terminal;
    logic             reload;
    logic             carry;
    logic [CNT_W-1:0] half_cur;
    logic [CNT_W-1:0] cnt_load;

    assign rate_change = (R_SBR != sbr_q);
    assign terminal    = (cnt == '0);
    assign reload      = terminal | rate_change;
    assign half_cur    = int_tbl[sbr_q] >> 1;

`ifdef ACIA_BRGEN_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] acc_next;

    // Phase accumulator step; a rate change restarts the dither from zero.
    always_comb begin
        {carry, acc_next} = {1'b0, acc} + {1'b0, frac_tbl[R_SBR]};
        if (rate_change) begin
            carry    = 1'b0;
            acc_next = '0;
        end
    end

    // Accumulator advances once per reload.
    always_ff @(posedge XTLI or negedge RESET) begin
        if (!RESET) begin
            acc <= '0;
        end else if (reload) begin
            acc <= acc_next;
        end
    end
`else
    assign carry = 1'b0;
`endif

    assign cnt_load = int_tbl[R_SBR] + CNT_W'(carry) - CNT_W'(1);

    // Down-counter with immediate restart on rate change; tick and BCLK phase.
    always_ff @(posedge XTLI or negedge RESET) begin
        if (!RESET) begin
            sbr_q     <= '0;
            cnt       <= '0;
            tx_tick_q <= 1'b0;
            bclk_q    <= 1'b0;
        end else begin
            if (reload) begin
                sbr_q     <= R_SBR;
                cnt       <= cnt_load;
                tx_tick_q <= terminal;
            end else begin
                cnt       <= cnt - CNT_W'(1);
                tx_tick_q <= 1'b0;
            end
            if (terminal) begin
                bclk_q <= 1'b1;
            end else if (cnt == half_cur) begin
                bclk_q <= 1'b0;
            end
        end
    end

    acia_tick_sync u_sync (
        .XTLI    (XTLI),
        .RESET   (RESET),
        .RXC_IN  (RXC_IN),
        .rx_tick (rx_tick_ext)
    );

    assign TX_TICK = tx_tick_q;
    assign RX_TICK = R_RCS ? tx_tick_q : rx_tick_ext;
    // SBR 0 has a one-cycle period, so the square wave is the crystal itself.
    assign BCLK    = (sbr_q == '0) ? XTLI : bclk_q;

endmodule

// File: tb/tb_acia_baud_gen.sv
// tb_acia_baud_gen: table-driven, scoreboarded bench for acia_baud_gen, with
// hand sequences for reset, rate change, external RxC and fractional dither.
module tb_acia_baud_gen;

    logic       XTLI;
    logic       RESET;
    logic [3:0] R_SBR;
    logic       R_RCS;
    logic       RXC_IN;
    logic       TX_TICK;
    logic       RX_TICK;
    logic       BCLK;

    logic [3:0] f_sbr;
    logic       f_rcs;
    logic       f_rxc;
    logic       f_tx;
    logic       f_rx;
    logic       f_bclk;

`ifdef ACIA_BRGEN_FRAC_EN
    localparam int F_TOTAL = 833;
    localparam int F_LONG  = 65;
`else
    localparam int F_TOTAL = 768;
    localparam int F_LONG  = 0;
`endif

    typedef struct {
        logic [3:0] sbr;
        int         period;
        int         bclk_hi;
        int         reps;
    } vec_t;

    typedef struct {
        logic [3:0] sbr;
        int         period;
        int         bclk_hi;
    } exp_t;

    localparam int NV = 14;
    vec_t vt [NV];
    exp_t sb_q [$];
    int   vec_gen;
    int   n_cmp;
    int   n_fail;

    acia_baud_gen dut (
        .XTLI    (XTLI),
        .RESET   (RESET),
        .R_SBR   (R_SBR),
        .R_RCS   (R_RCS),
        .RXC_IN  (RXC_IN),
        .TX_TICK (TX_TICK),
        .RX_TICK (RX_TICK),
        .BCLK    (BCLK)
    );

    acia_baud_gen #(.XTLI_FREQ(1_000_000)) dut_f (
        .XTLI    (XTLI),
        .RESET   (RESET),
        .R_SBR   (f_sbr),
        .R_RCS   (f_rcs),
        .RXC_IN  (f_rxc),
        .TX_TICK (f_tx),
        .RX_TICK (f_rx),
        .BCLK    (f_bclk)
    );

    initial begin
        XTLI = 1'b0;
        forever #5 XTLI = ~XTLI;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Counts negedges until the selected TX tick is seen; -1 on timeout.
    task automatic wait_tick(input bit use_f, input int limit, output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        while (!done) begin
            @(negedge XTLI);
            n++;
            if ((use_f ? f_tx : TX_TICK) == 1'b1) begin
                done = 1'b1;
            end else if (n >= limit) begin
                n    = -1;
                done = 1'b1;
            end
        end
    endtask

    // Scoreboard monitor: measures tick spacing and BCLK high time of dut.
    initial begin : monitor
        int   since;
        int   hi;
        int   seen_gen;
        bit   have_prev;
        exp_t e;
        since     = 0;
        hi        = 0;
        seen_gen  = 0;
        have_prev = 1'b0;
        forever begin
            @(negedge XTLI);
            if (!RESET) begin
                have_prev = 1'b0;
                since     = 0;
                hi        = 0;
            end else begin
                since++;
                if (BCLK) hi++;
                if (TX_TICK) begin
                    if (seen_gen != vec_gen) begin
                        seen_gen  = vec_gen;
                        have_prev = 1'b1;
                    end else if (have_prev && sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check($sformatf("sbr%0d_interval", e.sbr), since, e.period);
                        check($sformatf("sbr%0d_bclk_high", e.sbr), hi, e.bclk_hi);
                    end
                    since = 0;
                    hi    = 0;
                end
            end
        end
    end

    initial begin : stim
        int n;
        int budget;
        int lat;
        int pulses;
        int mism;
        int ticks;
        int total;
        int long_cnt;
        int bad;
        exp_t e;

        vt[0]  = '{4'd15, 6,    3,    4};
        vt[1]  = '{4'd14, 12,   6,    3};
        vt[2]  = '{4'd13, 16,   8,    3};
        vt[3]  = '{4'd12, 24,   12,   3};
        vt[4]  = '{4'd11, 32,   16,   3};
        vt[5]  = '{4'd10, 48,   24,   3};
        vt[6]  = '{4'd9,  64,   32,   2};
        vt[7]  = '{4'd8,  96,   48,   2};
        vt[8]  = '{4'd7,  192,  96,   2};
        vt[9]  = '{4'd6,  384,  192,  2};
        vt[10] = '{4'd5,  768,  384,  2};
        vt[11] = '{4'd2,  1536, 768,  2};
        vt[12] = '{4'd1,  2304, 1152, 2};
        vt[13] = '{4'd0,  1,    0,    4};

        n_cmp   = 0;
        n_fail  = 0;
        vec_gen = 0;
        RESET   = 1'b0;
        R_SBR   = 4'd0;
        R_RCS   = 1'b1;
        RXC_IN  = 1'b0;
        f_sbr   = 4'd15;
        f_rcs   = 1'b1;
        f_rxc   = 1'b0;

        // Reset state: no ticks, BCLK follows the crystal.
        #7;
        check("rst_tx_tick", int'(TX_TICK), 0);
        check("rst_rx_tick", int'(RX_TICK), 0);
        check("rst_bclk_clk_high", int'(BCLK), 1);
        #5;
        check("rst_bclk_clk_low", int'(BCLK), 0);

        // Release with SBR 15: first tick on the first edge.
        R_SBR = 4'd15;
        @(negedge XTLI); #1 RESET = 1'b1;
        wait_tick(1'b0, 10, n);
        check("first_tick_cycle", n, 1);

        // Table-driven steady-state periods through the scoreboard.
        for (int v = 0; v < NV; v++) begin
            @(negedge XTLI); #1;
            R_SBR = vt[v].sbr;
            vec_gen++;
            for (int k = 0; k < vt[v].reps; k++) begin
                e.sbr     = vt[v].sbr;
                e.period  = vt[v].period;
                e.bclk_hi = vt[v].bclk_hi;
                sb_q.push_back(e);
            end
            budget = (vt[v].reps + 2) * vt[v].period + 20;
            n = 0;
            while (sb_q.size() != 0 && n < budget) begin
                @(negedge XTLI);
                n++;
            end
            if (sb_q.size() != 0) begin
                check($sformatf("sbr%0d_timeout_pending", vt[v].sbr), sb_q.size(), 0);
                sb_q.delete();
            end
        end

        // Bypass: BCLK is the crystal and TX_TICK is always high.
        @(posedge XTLI); #1;
        check("bypass_bclk_high", int'(BCLK), 1);
        check("bypass_tick_high", int'(TX_TICK), 1);
        @(negedge XTLI); #1;
        check("bypass_bclk_low", int'(BCLK), 0);
        check("bypass_tick_low_phase", int'(TX_TICK), 1);

        // Rate change 8 -> 15 five cycles after a tick.
        R_SBR = 4'd8;
        wait_tick(1'b0, 200, n);
        wait_tick(1'b0, 200, n);
        check("sbr8_settle", n, 96);
        repeat (4) @(negedge XTLI);
        #1 R_SBR = 4'd15;
        @(negedge XTLI);
        check("rate_change_edge_no_tick", int'(TX_TICK), 0);
        wait_tick(1'b0, 20, n);
        check("rate_change_first", n, 6);
        wait_tick(1'b0, 20, n);
        check("rate_change_second", n, 6);
        wait_tick(1'b0, 20, n);
        check("rate_change_third", n, 6);

        // External RxC: one tick per rising edge, three edges after it.
        R_RCS = 1'b0;
        repeat (6) @(negedge XTLI);
        #1;
        for (int p = 0; p < 5; p++) begin
            RXC_IN = 1'b1;
            lat    = -1;
            pulses = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge XTLI);
                if (RX_TICK) begin
                    pulses++;
                    if (lat < 0) lat = i;
                end
                if (i == 5) #1 RXC_IN = 1'b0;
            end
            check($sformatf("ext_rx_latency_%0d", p), lat, 3);
            check($sformatf("ext_rx_pulses_%0d", p), pulses, 1);
            #1;
        end

        // Internal source: RX_TICK mirrors TX_TICK.
        R_RCS = 1'b1;
        mism  = 0;
        ticks = 0;
        repeat (42) begin
            @(negedge XTLI);
            if (RX_TICK != TX_TICK) mism++;
            if (TX_TICK) ticks++;
        end
        check("rcs1_rx_mismatch", mism, 0);
        check("rcs1_tick_count", ticks, 7);

        // Reset mid-operation at SBR 10, asserted while a tick is high.
        #1 R_SBR = 4'd10;
        wait_tick(1'b0, 100, n);
        wait_tick(1'b0, 100, n);
        #1 RESET = 1'b0;
        #1;
        check("midrst_tx_tick", int'(TX_TICK), 0);
        check("midrst_rx_tick", int'(RX_TICK), 0);
        @(posedge XTLI); #1;
        check("midrst_bclk_bypass", int'(BCLK), 1);
        check("midrst_tx_held", int'(TX_TICK), 0);
        @(negedge XTLI); #1 RESET = 1'b1;
        wait_tick(1'b0, 10, n);
        check("midrst_first_tick", n, 1);
        wait_tick(1'b0, 60, n);
        check("midrst_interval_1", n, 48);
        wait_tick(1'b0, 60, n);
        check("midrst_interval_2", n, 48);

        // Fractional dither at 1 MHz, SBR 15, over 256 intervals.
        wait_tick(1'b1, 10, n);
        wait_tick(1'b1, 10, n);
        check("f_bclk_at_tick", int'(f_bclk), 1);
        check("f_rx_follows_tx", int'(f_rx), int'(f_tx));
        total    = 0;
        long_cnt = 0;
        bad      = 0;
        for (int i = 0; i < 256; i++) begin
            wait_tick(1'b1, 10, n);
            if (n < 0) begin
                bad++;
            end else begin
                total += n;
                if (n == 4) long_cnt++;
                if (n < 3 || n > 4) bad++;
            end
        end
        check("frac_total_cycles", total, F_TOTAL);
        check("frac_long_intervals", long_cnt, F_LONG);
        check("frac_bad_intervals", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
